// File: rtl/radar_scan_sequencer.sv
// radar_scan_sequencer: steps a servo across SECTORS positions and fires one
// HC-SR04 ping per sector. Each ping is: settle wait, trigger pulse, wait for
// echo rise, measure echo high-time, store the result, then a dead-time gap.
//
// Ports:
//   clk        in   system clock, all logic on rising edge
//   rst        in   synchronous active-high reset
//   enable     in   run sweeps; when low, stops at the next IDLE return point
//   ech        in   raw asynchronous echo from the sensor
//   tk         out  trigger pulse to the sensor
//   sector     out  commanded servo sector index (0..SECTORS-1)
//   wr_en      out  one-cycle result-valid strobe
//   wr_addr    out  sector of the result
//   wr_data    out  echo high-time in clk cycles, saturated at ECHO_TIMEOUT
//   wr_timeout out  result is a timeout (no echo, or echo too long)
//   busy       out  high in every state except IDLE
//   sweep_done out  one-cycle pulse when the last sector of a sweep is stored
//
// Build option: define RADAR_SEQ_BOUNCE_EN to ping-pong the sector
// 0..SECTORS-1..0 instead of wrapping SECTORS-1 -> 0.
module radar_scan_sequencer #(
  parameter int unsigned SECTORS       = 7,
  parameter int unsigned SETTLE_CYCLES = 2700000,
  parameter int unsigned TRIG_CYCLES   = 270,
  parameter int unsigned ECHO_TIMEOUT  = 1000000,
  parameter int unsigned GAP_CYCLES    = 1620000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        ech,
  output logic        tk,
  output logic [3:0]  sector,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [19:0] wr_data,
  output logic        wr_timeout,
  output logic        busy,
  output logic        sweep_done
);

  localparam int unsigned SEC_W  = 4;
  localparam int unsigned DATA_W = 20;
  localparam int unsigned MAX_A  = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_B  = (ECHO_TIMEOUT > TRIG_CYCLES) ? ECHO_TIMEOUT : TRIG_CYCLES;
  localparam int unsigned MAX_W  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // Shared counter is at least 20 bits and wide enough for the longest wait
  localparam int unsigned CNT_W  = ($clog2(MAX_W + 1) > DATA_W) ? $clog2(MAX_W + 1) : DATA_W;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
  // The rise-detect cycle is already one high cycle, so MEASURE saturates one earlier
  localparam logic [CNT_W-1:0]  MEAS_LAST   = CNT_W'(ECHO_TIMEOUT - 2);
  localparam logic [DATA_W-1:0] TO_DATA     = DATA_W'(ECHO_TIMEOUT);
  localparam logic [SEC_W-1:0]  SEC_LAST    = SEC_W'(SECTORS - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, TRIG, WAIT_RISE, MEASURE, STORE, GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEC_W-1:0]    sector_q, sector_d;
  logic                ech_s1_q, ech_s1_d;
  logic                ech_s2_q, ech_s2_d;
  logic                tk_q, tk_d;
  logic                wr_en_q, wr_en_d;
  logic [SEC_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_timeout_q, wr_timeout_d;
  logic                busy_q, busy_d;
  logic                sweep_done_q, sweep_done_d;
  logic                at_end;
  logic                ech_s;
`ifdef RADAR_SEQ_BOUNCE_EN
  logic                dir_up_q, dir_up_d;
`endif

  assign ech_s = ech_s2_q;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sector_q     <= '0;
      ech_s1_q     <= 1'b0;
      ech_s2_q     <= 1'b0;
      tk_q         <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_timeout_q <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
`ifdef RADAR_SEQ_BOUNCE_EN
      dir_up_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sector_q     <= sector_d;
      ech_s1_q     <= ech_s1_d;
      ech_s2_q     <= ech_s2_d;
      tk_q         <= tk_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_timeout_q <= wr_timeout_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
`ifdef RADAR_SEQ_BOUNCE_EN
      dir_up_q     <= dir_up_d;
`endif
    end
  end

  // Next-state, counter, sector stepping and output staging
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    sector_d     = sector_q;
    ech_s1_d     = ech;
    ech_s2_d     = ech_s1_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_timeout_d = wr_timeout_q;
`ifdef RADAR_SEQ_BOUNCE_EN
    dir_up_d     = dir_up_q;
    at_end       = dir_up_q ? (sector_q == SEC_LAST) : (sector_q == '0);
`else
    at_end       = (sector_q == SEC_LAST);
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q >= TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end
      end
      WAIT_RISE: begin
        // Level-sensitive: an echo already high here is treated as a rise
        if (ech_s) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end else if (cnt_q >= WAIT_LAST) begin
          state_d      = STORE;
          cnt_d        = '0;
          wr_data_d    = TO_DATA;
          wr_timeout_d = 1'b1;
        end
      end
      MEASURE: begin
        // cnt_q counts high cycles after the detect cycle, hence the +1
        if (!ech_s) begin
          state_d      = STORE;
          cnt_d        = '0;
          wr_data_d    = DATA_W'(cnt_q + CNT_W'(1));
          wr_timeout_d = 1'b0;
        end else if (cnt_q >= MEAS_LAST) begin
          state_d      = STORE;
          cnt_d        = '0;
          wr_data_d    = TO_DATA;
          wr_timeout_d = 1'b1;
        end
      end
      STORE: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = '0;
          state_d = enable ? SETTLE : IDLE;
`ifdef RADAR_SEQ_BOUNCE_EN
          if (dir_up_q) begin
            if (sector_q == SEC_LAST) begin
              dir_up_d = 1'b0;
              sector_d = sector_q - SEC_W'(1);
            end else begin
              sector_d = sector_q + SEC_W'(1);
            end
          end else begin
            if (sector_q == '0) begin
              dir_up_d = 1'b1;
              sector_d = sector_q + SEC_W'(1);
            end else begin
              sector_d = sector_q - SEC_W'(1);
            end
          end
`else
          sector_d = (sector_q == SEC_LAST) ? '0 : sector_q + SEC_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are staged from the next state so they line up with it
    tk_d         = (state_d == TRIG);
    busy_d       = (state_d != IDLE);
    wr_en_d      = (state_d == STORE);
    sweep_done_d = (state_d == STORE) && at_end;
    if (state_d == STORE) wr_addr_d = sector_q;
  end

  assign tk         = tk_q;
  assign sector     = sector_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_timeout = wr_timeout_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_radar_scan_sequencer.sv
// Bench for radar_scan_sequencer with small timing parameters. Each ping's
// echo is described as a rise/fall pair in negedges after the trigger rise;
// the expected record comes from an arithmetic model of the ping timeline.
`timescale 1ns/1ps
module tb_radar_scan_sequencer;

  localparam int SECTORS = 3;
  localparam int SETTLE  = 8;
  localparam int TRIG    = 4;
  localparam int TIMEOUT = 100;
  localparam int GAP     = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        ech;
  logic        tk;
  logic [3:0]  sector;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [19:0] wr_data;
  logic        wr_timeout;
  logic        busy;
  logic        sweep_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  radar_scan_sequencer #(
    .SECTORS(SECTORS), .SETTLE_CYCLES(SETTLE), .TRIG_CYCLES(TRIG),
    .ECHO_TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ech(ech), .tk(tk),
    .sector(sector), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_timeout(wr_timeout), .busy(busy), .sweep_done(sweep_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sector visited by the p-th ping of a run
  function automatic int exp_sector(input int p);
`ifdef RADAR_SEQ_BOUNCE_EN
    int period;
    int m;
    period = 2 * (SECTORS - 1);
    m = p % period;
    return (m < SECTORS) ? m : period - m;
`else
    return p % SECTORS;
`endif
  endfunction

  function automatic bit exp_done(input int p);
    int s;
    s = exp_sector(p);
`ifdef RADAR_SEQ_BOUNCE_EN
    return (s == SECTORS - 1) || (s == 0 && p > 0);
`else
    return s == SECTORS - 1;
`endif
  endfunction

  // Echo high at trigger-relative negedges [a, f). The synchronised echo is
  // high over wait-window indices [a-2, f-2); the window opens at index 0 and
  // lasts TIMEOUT cycles, and the high time saturates at TIMEOUT.
  task automatic exp_result(input int a, input int f, output int d, output bit to);
    int k;
    int e;
    k = (a - 2 < 0) ? 0 : a - 2;
    e = f - 2;
    if (e <= k || k >= TIMEOUT) begin
      d = TIMEOUT; to = 1'b1;
    end else if (e - k >= TIMEOUT) begin
      d = TIMEOUT; to = 1'b1;
    end else begin
      d = e - k; to = 1'b0;
    end
  endtask

  task automatic rand_plan(output int a, output int f);
    case ($urandom_range(0, 3))
      0:       begin a = 10000; f = 10000; end
      1:       begin a = $urandom_range(4, 110); f = a + $urandom_range(1, 99); end
      2:       begin a = $urandom_range(4, 40);  f = a + $urandom_range(95, 150); end
      default: begin a = -1; f = $urandom_range(3, 60); end
    endcase
  endtask

  // One full ping: called and returns on a negedge with tk low
  task automatic do_ping(input int p, input int a, input int f, input bit drop_en, input bit chk_lat);
    int i;
    int n;
    int lat;
    int tk_hi;
    int ed;
    bit eto;
    bit seen;
    ech = (a < 0);
    i = 0;
    lat = 0;
    while (tk !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
      if (busy === 1'b1 && tk !== 1'b1) lat++;
    end
    chk("tk_rise_seen", 32'(tk), 1);
    if (chk_lat) chk("first_trig_latency", lat, SETTLE);
    chk("sector_at_trig", 32'(sector), exp_sector(p));
    n = 0;
    tk_hi = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      if (tk === 1'b1) tk_hi++;
      if (wr_en === 1'b1) begin
        seen = 1'b1;
      end else begin
        ech = (n >= a) && (n < f);
        if (drop_en && n == a + 5) enable = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    exp_result(a, f, ed, eto);
    chk("wr_en_seen", 32'(seen), 1);
    chk("trig_width", tk_hi, TRIG);
    chk("wr_addr", 32'(wr_addr), exp_sector(p));
    chk("wr_data", 32'(wr_data), ed);
    chk("wr_timeout", 32'(wr_timeout), 32'(eto));
    chk("sweep_done", 32'(sweep_done), 32'(exp_done(p)));
    @(negedge clk);
    chk("wr_en_strobe", 32'(wr_en), 0);
    chk("sweep_done_strobe", 32'(sweep_done), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tk"}, 32'(tk), 0);
    chk({tag, "_sector"}, 32'(sector), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_wr_timeout"}, 32'(wr_timeout), 0);
    chk({tag, "_sweep_done"}, 32'(sweep_done), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int a;
    int f;
    int i;
    int tkc;
    int wrc;

    rst = 1'b1; enable = 1'b0; ech = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0; enable = 1'b1;

    // Directed pings, then randomized ones
    p = 0;
    do_ping(p, 10000, 10000, 1'b0, 1'b1); p++;  // no echo
    do_ping(p, 10, 47, 1'b0, 1'b0);       p++;  // 37-cycle echo
    do_ping(p, 6, 156, 1'b0, 1'b0);       p++;  // stuck high, saturates
    do_ping(p, -1, 30, 1'b0, 1'b0);       p++;  // carried-over high echo
    do_ping(p, 101, 111, 1'b0, 1'b0);     p++;  // rise on last wait cycle
    do_ping(p, 102, 112, 1'b0, 1'b0);     p++;  // rise just after wait window
    do_ping(p, 10, 109, 1'b0, 1'b0);      p++;  // width TIMEOUT-1
    do_ping(p, 10, 110, 1'b0, 1'b0);      p++;  // width TIMEOUT
    for (int r = 0; r < 8; r++) begin
      rand_plan(a, f);
      do_ping(p, a, f, 1'b0, 1'b0);
      p++;
    end

    // enable dropped mid-measure: ping completes, then the block idles
    do_ping(p, 10, 40, 1'b1, 1'b0); p++;
    tkc = 0; wrc = 0;
    repeat (12) begin
      @(negedge clk);
      if (tk === 1'b1) tkc++;
      if (wr_en === 1'b1) wrc++;
    end
    chk("idle_busy", 32'(busy), 0);
    chk("idle_no_trig", tkc, 0);
    chk("idle_no_store", wrc, 0);
    chk("idle_sector", 32'(sector), exp_sector(p));

    enable = 1'b1;
    rand_plan(a, f);
    do_ping(p, a, f, 1'b0, 1'b0); p++;

    // Reset during the second trigger cycle
    ech = 1'b0;
    i = 0;
    while (tk !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("rst_test_trig_seen", 32'(tk), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_trig_reset");
    rst = 1'b0;

    p = 0;
    do_ping(p, 10000, 10000, 1'b0, 1'b1); p++;
    for (int r = 0; r < 3; r++) begin
      rand_plan(a, f);
      do_ping(p, a, f, 1'b0, 1'b0);
      p++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
